// File: rtl/bin_to_bcd_digits.sv
// Double-dabble binary-to-BCD converter: one bit per clock, WIDTH edges from accept to done; start ignored while busy.
// Optional BCD_OVF_SAT_EN: saturate the displayed digits to 9999 when the value exceeds four digits.
module bin_to_bcd_digits #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [3:0]       num3,
  output logic [3:0]       num2,
  output logic [3:0]       num1,
  output logic [3:0]       num0,
  output logic             ovf
);

  localparam int CW = 5;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_bin;
  logic [19:0]      r_scratch;
  logic [CW-1:0]    r_cnt;
  logic [15:0]      r_num;
  logic             r_ovf;
  logic             r_done;
  logic             r_busy;

  logic [19:0]      w_adj;
  logic [20:0]      w_shift;
  logic             w_accept;
  logic             w_last;
  logic             w_ovf;
  logic [15:0]      w_digits;

  // Each digit corrected independently with a 4-bit adder; no carry crosses digits.
  always_comb begin
    w_adj = r_scratch;
    for (int d = 0; d < 5; d++) begin
      if (r_scratch[d*4 +: 4] >= 4'd5) begin
        w_adj[d*4 +: 4] = r_scratch[d*4 +: 4] + 4'd3;
      end
    end
  end

  assign w_shift  = {w_adj, r_bin[WIDTH-1]};
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(1));
  assign w_ovf    = (w_shift[20:16] != 5'd0);

`ifdef BCD_OVF_SAT_EN
  assign w_digits = w_ovf ? 16'h9999 : w_shift[15:0];
`else
  assign w_digits = w_shift[15:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == CW'(1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_num     <= '0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= w_last;
      r_busy <= (w_state_nxt == S_SHIFT);
      if (w_accept) begin
        r_bin     <= value;
        r_scratch <= '0;
        r_cnt     <= CW'(WIDTH);
      end else if (r_state == S_SHIFT) begin
        r_bin     <= {r_bin[WIDTH-2:0], 1'b0};
        r_scratch <= w_shift[19:0];
        r_cnt     <= r_cnt - CW'(1);
      end
      // Results only move on the final shift, so the display never sees partial digits.
      if (w_last) begin
        r_num <= w_digits;
        r_ovf <= w_ovf;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign num3 = r_num[15:12];
  assign num2 = r_num[11:8];
  assign num1 = r_num[7:4];
  assign num0 = r_num[3:0];
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Directed bench for bin_to_bcd_digits at WIDTH=16; expectations follow BCD_OVF_SAT_EN if defined.
module tb_bin_to_bcd_digits;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic [3:0]  num3, num2, num1, num0;
  logic        ovf;

  int tests_run;
  int tests_failed;

  bin_to_bcd_digits #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .num3  (num3),
    .num2  (num2),
    .num1  (num1),
    .num0  (num0),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge, then wait (bounded) for busy to fall; ends on the done-cycle negedge.
  task automatic run_conv(input logic [15:0] v, output int busy_cycles, output logic got_done);
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 40) begin
      busy_cycles++;
      @(negedge clk);
    end
    got_done = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    value = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, done, ovf, num3, num2, num1, num0} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b done=%b ovf=%b digits=%h%h%h%h, want all 0",
               busy, done, ovf, num3, num2, num1, num0);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int n;
    logic d;
    run_conv(16'd0, n, d);
    tests_run++;
    if (n !== 16) begin
      tests_failed++;
      $display("FAIL zero_busy_len: got %0d busy cycles, want 16", n);
    end
    tests_run++;
    if (d !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_done: got done=%b, want 1", d);
    end
    tests_run++;
    if ({ovf, num3, num2, num1, num0} !== 17'h00000) begin
      tests_failed++;
      $display("FAIL zero_digits: got ovf=%b digits=%h%h%h%h, want 0 0000", ovf, num3, num2, num1, num0);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_one_cycle: got done=%b a cycle later, want 0", done);
    end
  endtask

  task automatic test_values();
    logic [15:0] vin  [4];
    logic [15:0] vexp [4];
    logic        vovf [4];
    int n;
    logic d;
    vin[0] = 16'h04D2; vexp[0] = 16'h1234; vovf[0] = 1'b0;
    vin[1] = 16'd9999; vexp[1] = 16'h9999; vovf[1] = 1'b0;
`ifdef BCD_OVF_SAT_EN
    vin[2] = 16'd10000; vexp[2] = 16'h9999; vovf[2] = 1'b1;
    vin[3] = 16'd65535; vexp[3] = 16'h9999; vovf[3] = 1'b1;
`else
    vin[2] = 16'd10000; vexp[2] = 16'h0000; vovf[2] = 1'b1;
    vin[3] = 16'd65535; vexp[3] = 16'h5535; vovf[3] = 1'b1;
`endif
    for (int i = 0; i < 4; i++) begin
      run_conv(vin[i], n, d);
      tests_run++;
      if (d !== 1'b1 || {num3, num2, num1, num0} !== vexp[i] || ovf !== vovf[i]) begin
        tests_failed++;
        $display("FAIL value_%0d: got done=%b digits=%h%h%h%h ovf=%b, want done=1 digits=%h ovf=%b",
                 vin[i], d, num3, num2, num1, num0, ovf, vexp[i], vovf[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    logic [15:0] cap;
    dones = 0;
    cap = 16'hFFFF;
    @(negedge clk);
    start = 1'b1;
    value = 16'd1234;
    @(negedge clk);
    start = 1'b0;
    value = 16'd999;
    // Digits must stay at the previous result (65535 case) while shifting.
    repeat (4) @(negedge clk);
    tests_run++;
`ifdef BCD_OVF_SAT_EN
    if ({num3, num2, num1, num0} !== 16'h9999) begin
`else
    if ({num3, num2, num1, num0} !== 16'h5535) begin
`endif
      tests_failed++;
      $display("FAIL hold_during_shift: got digits=%h%h%h%h, previous result expected", num3, num2, num1, num0);
    end
    start = 1'b1;
    value = 16'd42;
    @(negedge clk);
    start = 1'b0;
    value = 16'd7;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        dones++;
        cap = {num3, num2, num1, num0};
      end
      @(negedge clk);
    end
    tests_run++;
    if (dones !== 1 || cap !== 16'h1234) begin
      tests_failed++;
      $display("FAIL ignore_start: got %0d dones digits=%h, want 1 done digits=1234", dones, cap);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic d;
    run_conv(16'd1234, n, d);
    start = 1'b1;
    value = 16'd42;
    @(negedge clk);
    n = 1;
    start = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n !== 17 || {num3, num2, num1, num0} !== 16'h0042 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_back: got done after %0d cycles digits=%h%h%h%h ovf=%b, want 17 0042 0",
               n, num3, num2, num1, num0, ovf);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    int n;
    logic d;
    dones = 0;
    @(negedge clk);
    start = 1'b1;
    value = 16'd1234;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, ovf, num3, num2, num1, num0} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_async: got busy=%b done=%b ovf=%b digits=%h%h%h%h, want all 0",
               busy, done, ovf, num3, num2, num1, num0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_done: got %0d dones after abort, want 0", dones);
    end
    run_conv(16'd7, n, d);
    tests_run++;
    if (d !== 1'b1 || {num3, num2, num1, num0} !== 16'h0007 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset_7: got done=%b digits=%h%h%h%h ovf=%b, want 1 0007 0",
               d, num3, num2, num1, num0, ovf);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_zero();
    test_values();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
